// File: rtl/program_run_monitor_pkg.sv
// Shared definitions for the program run monitor: FSM state encoding,
// register index width and the "no failure" index marker.
package program_run_monitor_pkg;

   localparam logic [2:0] STATE_IDLE  = 3'd0;
   localparam logic [2:0] STATE_RUN   = 3'd1;
   localparam logic [2:0] STATE_DRAIN = 3'd2;
   localparam logic [2:0] STATE_CHECK = 3'd3;
   localparam logic [2:0] STATE_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = STATE_IDLE,
      ST_RUN   = STATE_RUN,
      ST_DRAIN = STATE_DRAIN,
      ST_CHECK = STATE_CHECK,
      ST_DONE  = STATE_DONE
   } monitor_state_t;

   localparam int REG_INDEX_BITS = 5;

   // Wide enough for any fail_index; users slice the low bits they need.
   localparam logic [31:0] NO_FAIL = '1;

endpackage

// File: rtl/halt_address_matcher.sv
// Comparator bank: flags when the fetch PC equals any of the packed halt addresses.
module halt_address_matcher
   import program_run_monitor_pkg::*;
#(
   parameter int NUM_HALT_ADDRS = 2,
   parameter int ADDRESS_BITS   = 32
) (
   input  logic [ADDRESS_BITS-1:0]                pc,
   input  logic [NUM_HALT_ADDRS*ADDRESS_BITS-1:0] halt_addrs,
   output logic                                   match
);

   // OR together one equality compare per halt-address slot.
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < NUM_HALT_ADDRS; i++) begin
         if (halt_addrs[i*ADDRESS_BITS +: ADDRESS_BITS] == pc) begin
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/program_run_monitor.sv
// Program run monitor: counts run cycles from a start pulse until the PC hits a
// halt address (or a timeout expires), waits a drain interval, then reads back
// and compares up to NUM_CHECKS register-file entries.
// Optional macro PROGRAM_RUN_MONITOR_FULL_SCAN_EN: evaluate every check instead
// of stopping at the first mismatch.
module program_run_monitor
   import program_run_monitor_pkg::*;
#(
   parameter int ADDRESS_BITS   = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_HALT_ADDRS = 2,
   parameter int NUM_CHECKS     = 4,
   parameter int CYCLE_BITS     = 32,
   parameter int DRAIN_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [ADDRESS_BITS-1:0]                PC,
   input  logic [NUM_HALT_ADDRS*ADDRESS_BITS-1:0] halt_addrs,
   input  logic [NUM_CHECKS-1:0]                  check_enable,
   input  logic [NUM_CHECKS*REG_INDEX_BITS-1:0]   check_reg_addrs,
   input  logic [NUM_CHECKS*DATA_WIDTH-1:0]       expected_values,
   output logic [REG_INDEX_BITS-1:0]              reg_read_addr,
   input  logic [DATA_WIDTH-1:0]                  reg_read_data,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   pass,
   output logic                                   timeout,
   output logic [CYCLE_BITS-1:0]                  total_cycles,
   output logic [$clog2(NUM_CHECKS):0]            fail_index,
   output logic [DATA_WIDTH-1:0]                  fail_data,
   output logic [NUM_CHECKS-1:0]                  fail_mask
);

   localparam int FAIL_INDEX_BITS  = $clog2(NUM_CHECKS) + 1;
   localparam int CHECK_INDEX_BITS = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
   localparam int DRAIN_COUNT_BITS = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [FAIL_INDEX_BITS-1:0] NO_FAIL_INDEX = NO_FAIL[FAIL_INDEX_BITS-1:0];

`ifdef PROGRAM_RUN_MONITOR_FULL_SCAN_EN
   localparam bit STOP_AT_FIRST_FAIL = 1'b0;
`else
   localparam bit STOP_AT_FIRST_FAIL = 1'b1;
`endif

   monitor_state_t              state, state_nx;
   logic [CYCLE_BITS-1:0]       cycle_count, cycle_count_nx, cycle_count_inc;
   logic [DRAIN_COUNT_BITS-1:0] drain_count, drain_count_nx;
   logic [CHECK_INDEX_BITS-1:0] check_index, check_index_nx;
   logic                        pass_nx, timeout_nx;
   logic [CYCLE_BITS-1:0]       total_cycles_nx;
   logic [FAIL_INDEX_BITS-1:0]  fail_index_nx;
   logic [DATA_WIDTH-1:0]       fail_data_nx;
   logic [NUM_CHECKS-1:0]       fail_mask_nx, fail_mask_upd;
   logic                        halt_match;
   logic                        cur_mismatch;

   logic [REG_INDEX_BITS-1:0]   reg_addr_arr [NUM_CHECKS];
   logic [DATA_WIDTH-1:0]       expected_arr [NUM_CHECKS];

   for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_unpack
      assign reg_addr_arr[i] = check_reg_addrs[i*REG_INDEX_BITS +: REG_INDEX_BITS];
      assign expected_arr[i] = expected_values[i*DATA_WIDTH +: DATA_WIDTH];
   end

   halt_address_matcher #(
      .NUM_HALT_ADDRS (NUM_HALT_ADDRS),
      .ADDRESS_BITS   (ADDRESS_BITS)
   ) u_matcher (
      .pc         (PC),
      .halt_addrs (halt_addrs),
      .match      (halt_match)
   );

   // Next-state, next-result and status outputs; everything holds by default.
   always_comb begin
      state_nx        = state;
      cycle_count_nx  = cycle_count;
      drain_count_nx  = drain_count;
      check_index_nx  = check_index;
      pass_nx         = pass;
      timeout_nx      = timeout;
      total_cycles_nx = total_cycles;
      fail_index_nx   = fail_index;
      fail_data_nx    = fail_data;
      fail_mask_nx    = fail_mask;

      cycle_count_inc = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
      cur_mismatch    = check_enable[check_index] &&
                        (reg_read_data != expected_arr[check_index]);
      fail_mask_upd   = fail_mask | (cur_mismatch ? (NUM_CHECKS'(1) << check_index)
                                                  : {NUM_CHECKS{1'b0}});

      busy          = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_CHECK);
      done          = (state == ST_DONE);
      reg_read_addr = (state == ST_CHECK) ? reg_addr_arr[check_index] : '0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx        = ST_RUN;
               cycle_count_nx  = '0;
               pass_nx         = 1'b0;
               timeout_nx      = 1'b0;
               total_cycles_nx = '0;
               fail_index_nx   = NO_FAIL_INDEX;
               fail_data_nx    = '0;
               fail_mask_nx    = '0;
            end
         end
         ST_RUN: begin
            cycle_count_nx = cycle_count_inc;
            // A halt match on the timeout edge takes priority over the timeout.
            if (halt_match) begin
               state_nx        = ST_DRAIN;
               total_cycles_nx = cycle_count_inc;
               drain_count_nx  = '0;
            end else if ((TIMEOUT_CYCLES != 0) &&
                         (cycle_count_inc == CYCLE_BITS'(TIMEOUT_CYCLES))) begin
               state_nx        = ST_DONE;
               timeout_nx      = 1'b1;
               pass_nx         = 1'b0;
               total_cycles_nx = CYCLE_BITS'(TIMEOUT_CYCLES);
            end
         end
         ST_DRAIN: begin
            if (drain_count == DRAIN_COUNT_BITS'(DRAIN_CYCLES)) begin
               state_nx       = ST_CHECK;
               check_index_nx = '0;
            end else begin
               drain_count_nx = drain_count + 1'b1;
            end
         end
         ST_CHECK: begin
            fail_mask_nx = fail_mask_upd;
            if (cur_mismatch && (fail_mask == '0)) begin
               fail_index_nx = FAIL_INDEX_BITS'(check_index);
               fail_data_nx  = reg_read_data;
            end
            if (cur_mismatch && STOP_AT_FIRST_FAIL) begin
               state_nx = ST_DONE;
               pass_nx  = 1'b0;
            end else if (check_index == CHECK_INDEX_BITS'(NUM_CHECKS - 1)) begin
               state_nx = ST_DONE;
               pass_nx  = (fail_mask_upd == '0);
            end else begin
               check_index_nx = check_index + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State and result registers; reset aborts any run and reports "no failure".
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cycle_count  <= '0;
         drain_count  <= '0;
         check_index  <= '0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         total_cycles <= '0;
         fail_index   <= NO_FAIL_INDEX;
         fail_data    <= '0;
         fail_mask    <= '0;
      end else begin
         state        <= state_nx;
         cycle_count  <= cycle_count_nx;
         drain_count  <= drain_count_nx;
         check_index  <= check_index_nx;
         pass         <= pass_nx;
         timeout      <= timeout_nx;
         total_cycles <= total_cycles_nx;
         fail_index   <= fail_index_nx;
         fail_data    <= fail_data_nx;
         fail_mask    <= fail_mask_nx;
      end
   end

endmodule

// File: tb/tb_program_run_monitor.sv
// Testbench for program_run_monitor: directed scenarios with literal pins plus
// randomized runs, all checked every cycle against a timeline model.
module tb_program_run_monitor;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int NH  = 2;
   localparam int NC  = 4;
   localparam int CB  = 32;
   localparam int TB_D = 5;
   localparam int TB_T = 1000;
   localparam int FIW = 3;

`ifdef PROGRAM_RUN_MONITOR_FULL_SCAN_EN
   localparam bit FULL_SCAN = 1'b1;
`else
   localparam bit FULL_SCAN = 1'b0;
`endif

   logic              clock;
   logic              reset;
   logic              start;
   logic [AW-1:0]     pc;
   logic [NH*AW-1:0]  halt_addrs;
   logic [NC-1:0]     check_enable;
   logic [NC*5-1:0]   check_reg_addrs;
   logic [NC*DW-1:0]  expected_values;
   logic [4:0]        reg_read_addr;
   logic [DW-1:0]     reg_read_data;
   logic              busy, done, pass, timeout;
   logic [CB-1:0]     total_cycles;
   logic [FIW-1:0]    fail_index;
   logic [DW-1:0]     fail_data;
   logic [NC-1:0]     fail_mask;

   logic [AW-1:0]     tb_halt [NH];
   logic [4:0]        tb_raddr [NC];
   logic [DW-1:0]     tb_expv [NC];
   logic [DW-1:0]     regfile [32];

   // Model of the current run, committed at the start edge.
   int                model_mode;
   int                run_n;
   int                run_id;
   bit                m_is_timeout;
   int                m_done_edge, m_check_start;
   logic [CB-1:0]     m_total;
   logic              m_pass, m_timeout;
   logic [FIW-1:0]    m_idx;
   logic [DW-1:0]     m_data;
   logic [NC-1:0]     m_mask;
   logic [4:0]        m_addr [NC];

   // Literal pins for directed runs.
   bit                pin_active;
   int                pin_done_edge;
   logic [CB-1:0]     pin_total;
   logic              pin_pass, pin_timeout;
   logic [FIW-1:0]    pin_idx;
   logic [DW-1:0]     pin_data;
   logic [NC-1:0]     pin_mask;
   int                pin_run_seen;

   int                checks;
   int                errors;
   logic              exp_done;
   logic [4:0]        exp_addr;
   logic [1:0]        ci;

   for (genvar i = 0; i < NH; i++) begin : g_pack_halt
      assign halt_addrs[i*AW +: AW] = tb_halt[i];
   end
   for (genvar i = 0; i < NC; i++) begin : g_pack_chk
      assign check_reg_addrs[i*5 +: 5]   = tb_raddr[i];
      assign expected_values[i*DW +: DW] = tb_expv[i];
   end
   assign reg_read_data = regfile[reg_read_addr];

   program_run_monitor #(
      .ADDRESS_BITS   (AW),
      .DATA_WIDTH     (DW),
      .NUM_HALT_ADDRS (NH),
      .NUM_CHECKS     (NC),
      .CYCLE_BITS     (CB),
      .DRAIN_CYCLES   (TB_D),
      .TIMEOUT_CYCLES (TB_T)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .PC              (pc),
      .halt_addrs      (halt_addrs),
      .check_enable    (check_enable),
      .check_reg_addrs (check_reg_addrs),
      .expected_values (expected_values),
      .reg_read_addr   (reg_read_addr),
      .reg_read_data   (reg_read_data),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .timeout         (timeout),
      .total_cycles    (total_cycles),
      .fail_index      (fail_index),
      .fail_data       (fail_data),
      .fail_mask       (fail_mask)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (run %0d, edge %0d)",
                  name, actual, expected, run_id, run_n);
      end
   endtask

   // Compare process: DUT outputs against the model on every falling edge.
   always @(negedge clock) begin
      if (model_mode == 1) begin
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_done", done, 0);
         checkOutput("rst_pass", pass, 0);
         checkOutput("rst_timeout", timeout, 0);
         checkOutput("rst_total", total_cycles, 0);
         checkOutput("rst_fail_index", fail_index, 7);
         checkOutput("rst_fail_data", fail_data, 0);
         checkOutput("rst_fail_mask", fail_mask, 0);
         checkOutput("rst_reg_addr", reg_read_addr, 0);
      end else if (model_mode == 2) begin
         exp_done = (run_n >= m_done_edge);
         exp_addr = '0;
         if (!m_is_timeout && run_n >= m_check_start && run_n < m_done_edge) begin
            ci       = 2'(run_n - m_check_start);
            exp_addr = m_addr[ci];
         end
         checkOutput("busy", busy, !exp_done);
         checkOutput("done", done, exp_done);
         checkOutput("reg_read_addr", reg_read_addr, exp_addr);
         if (exp_done) begin
            checkOutput("pass", pass, m_pass);
            checkOutput("timeout", timeout, m_timeout);
            checkOutput("total_cycles", total_cycles, m_total);
            checkOutput("fail_index", fail_index, m_idx);
            checkOutput("fail_data", fail_data, m_data);
            checkOutput("fail_mask", fail_mask, m_mask);
         end
         if (pin_active && done && pin_run_seen != run_id) begin
            pin_run_seen = run_id;
            checkOutput("pin_done_edge", run_n, pin_done_edge);
            checkOutput("pin_total", total_cycles, pin_total);
            checkOutput("pin_pass", pass, pin_pass);
            checkOutput("pin_timeout", timeout, pin_timeout);
            checkOutput("pin_fail_index", fail_index, pin_idx);
            checkOutput("pin_fail_data", fail_data, pin_data);
            checkOutput("pin_fail_mask", fail_mask, pin_mask);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [AW-1:0] nonmatch();
      logic [AW-1:0] v;
      bit            hit;
      do begin
         v   = $urandom;
         hit = 1'b0;
         for (int i = 0; i < NH; i++) if (v == tb_halt[i]) hit = 1'b1;
      end while (hit);
      return v;
   endfunction

   // One run: plan the expected timeline, pulse start, drive PC per edge.
   // halt_edge 0 means the PC never matches; abort_at>0 resets at that edge.
   task automatic applyStimulus(input int halt_edge, input int halt_sel,
                                input int abort_at, input bit use_pins);
      bit            is_to;
      int            first, n_chk, done_e, chk_s, m, sel;
      logic [NC-1:0] mism;
      logic [DW-1:0] fdata;

      is_to = (halt_edge == 0) || (halt_edge > TB_T);
      mism  = '0;
      first = -1;
      fdata = '0;
      for (int k = 0; k < NC; k++) begin
         if (check_enable[k] && regfile[tb_raddr[k]] != tb_expv[k]) begin
            mism[k] = 1'b1;
            if (first < 0) begin
               first = k;
               fdata = regfile[tb_raddr[k]];
            end
         end
      end
      if (FULL_SCAN) n_chk = NC;
      else           n_chk = (first < 0) ? NC : first + 1;
      chk_s  = halt_edge + TB_D + 1;
      done_e = is_to ? TB_T : chk_s + n_chk;

      start = 1'b1;
      pc    = nonmatch();
      step();
      start = 1'b0;
      m_is_timeout  = is_to;
      m_done_edge   = done_e;
      m_check_start = chk_s;
      for (int k = 0; k < NC; k++) m_addr[k] = tb_raddr[k];
      if (is_to) begin
         m_total = CB'(TB_T); m_pass = 1'b0; m_timeout = 1'b1;
         m_idx = '1; m_data = '0; m_mask = '0;
      end else begin
         m_total   = CB'(halt_edge);
         m_pass    = (mism == '0);
         m_timeout = 1'b0;
         m_idx     = (first < 0) ? 3'b111 : FIW'(first);
         m_data    = fdata;
         m_mask    = FULL_SCAN ? mism : ((first < 0) ? '0 : NC'(1) << first);
      end
      run_n      = 0;
      run_id     = run_id + 1;
      model_mode = 2;
      pin_active = use_pins;

      while (run_n < done_e + 3) begin
         if (abort_at > 0 && run_n == abort_at) begin
            reset = 1'b1;
            step();
            reset      = 1'b0;
            model_mode = 1;
            pin_active = 1'b0;
            return;
         end
         m = run_n + 1;
         if (!is_to && m == halt_edge) begin
            sel = (halt_sel < 0) ? $urandom_range(0, NH - 1) : halt_sel;
            pc  = tb_halt[sel];
         end else if ((is_to && m <= TB_T) || (!is_to && m < halt_edge)) begin
            pc = nonmatch();
         end else begin
            pc = ($urandom_range(0, 1) == 1) ? tb_halt[$urandom_range(0, NH - 1)] : $urandom;
         end
         start = (run_n < done_e) && ($urandom_range(0, 15) == 0);
         step();
         run_n = run_n + 1;
      end
      start      = 1'b0;
      pin_active = 1'b0;
   endtask

   task automatic setPins(input int de, input int tot, input logic p, input logic to,
                          input logic [FIW-1:0] idx, input logic [DW-1:0] d,
                          input logic [NC-1:0] mk);
      pin_done_edge = de; pin_total = CB'(tot); pin_pass = p; pin_timeout = to;
      pin_idx = idx; pin_data = d; pin_mask = mk;
   endtask

   task automatic setupBasic(input logic [DW-1:0] reg9);
      tb_halt[0] = 32'hA8;
      tb_halt[1] = 32'hAC;
      for (int r = 0; r < 32; r++) regfile[r] = $urandom;
      for (int k = 0; k < NC; k++) begin
         tb_raddr[k] = 5'(k);
         tb_expv[k]  = $urandom;
      end
      tb_raddr[0]  = 5'd9;
      tb_expv[0]   = 32'h15;
      regfile[9]   = reg9;
      check_enable = 4'b0001;
   endtask

   task automatic randomizeSetup();
      for (int i = 0; i < NH; i++) tb_halt[i] = $urandom;
      for (int r = 0; r < 32; r++) regfile[r] = $urandom;
      for (int k = 0; k < NC; k++) begin
         tb_raddr[k] = 5'($urandom_range(0, 31));
         tb_expv[k]  = ($urandom_range(0, 2) != 0) ? regfile[tb_raddr[k]] : $urandom;
      end
      check_enable = NC'($urandom);
   endtask

   initial begin
      checks = 0; errors = 0;
      model_mode = 0; run_n = 0; run_id = 0; pin_run_seen = -1; pin_active = 1'b0;
      reset = 1'b1; start = 1'b0; pc = '0;
      setupBasic(32'h15);
      setPins(0, 0, 0, 0, 0, 0, 0);
      step();
      model_mode = 1;
      step();
      reset = 1'b0;
      step();
      step();

      $display("[TB] halt at edge 120, check passes");
      setupBasic(32'h15);
      setPins(130, 120, 1'b1, 1'b0, 3'b111, 0, 4'b0000);
      applyStimulus(120, 0, 0, 1'b1);

      $display("[TB] halt at edge 120, check 0 mismatches");
      setupBasic(32'h14);
      setPins(FULL_SCAN ? 130 : 127, 120, 1'b0, 1'b0, 3'd0, 32'h14, 4'b0001);
      applyStimulus(120, 0, 0, 1'b1);

      $display("[TB] no halt, timeout at 1000");
      setupBasic(32'h15);
      setPins(1000, 1000, 1'b0, 1'b1, 3'b111, 0, 4'b0000);
      applyStimulus(0, 0, 0, 1'b1);

      $display("[TB] checks 1 and 3 mismatch");
      setupBasic(32'h15);
      check_enable = 4'b1111;
      tb_raddr[1] = 5'd10; tb_raddr[2] = 5'd11; tb_raddr[3] = 5'd12;
      regfile[10] = 32'h22; tb_expv[1] = 32'h23;
      regfile[11] = 32'h33; tb_expv[2] = 32'h33;
      regfile[12] = 32'h44; tb_expv[3] = 32'h45;
      setPins(FULL_SCAN ? 40 : 38, 30, 1'b0, 1'b0, 3'd1, 32'h22,
              FULL_SCAN ? 4'b1010 : 4'b0010);
      applyStimulus(30, -1, 0, 1'b1);

      $display("[TB] reset during drain, then fresh run");
      setupBasic(32'h15);
      applyStimulus(20, -1, 22, 1'b0);
      step();
      setPins(25, 15, 1'b1, 1'b0, 3'b111, 0, 4'b0000);
      applyStimulus(15, -1, 0, 1'b1);

      $display("[TB] halt on the timeout edge");
      setupBasic(32'h15);
      setPins(1010, 1000, 1'b1, 1'b0, 3'b111, 0, 4'b0000);
      applyStimulus(1000, 1, 0, 1'b1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 24; r++) begin
         randomizeSetup();
         applyStimulus($urandom_range(0, 80), -1,
                       ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0, 1'b0);
      end

      model_mode = 0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
